// File: rtl/bp_ctrl.sv
// Dynamic branch-prediction controller: 2-bit BHT, in-flight prediction FIFO and mispredict flush.
// Optional build macro BP_BHT_BYPASS_EN forwards a same-cycle BHT update to the lookup.
module bp_ctrl #(
  parameter int BHT_IDX_W = 4,
  parameter int QDEPTH    = 4,
  parameter int QPTR_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        bp_isbranch_i,
  input  logic [31:0] bp_target_i,
  input  logic        ex_resolve_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_addr_o,
  output logic        flush_o,
  output logic [31:0] flush_addr_o,
  output logic        q_full_o
);

  localparam logic [1:0] S_INIT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;
  localparam int         BHT_N   = 1 << BHT_IDX_W;

  function automatic logic [1:0] sat_upd(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    end else begin
      res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    end
    return res;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [BHT_IDX_W-1:0] init_idx_q, init_idx_d;
  logic [1:0]           bht_q [BHT_N];
  logic                 qe_taken_q  [QDEPTH];
  logic [31:0]          qe_target_q [QDEPTH];
  logic [31:0]          qe_fall_q   [QDEPTH];
  logic [BHT_IDX_W-1:0] qe_idx_q    [QDEPTH];
  logic [QPTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QPTR_W:0]      cnt_q, cnt_d;
  logic                 flush_q;
  logic [31:0]          flush_addr_q, flush_addr_d;

  logic                 run_s, empty_s, full_s, pop_s, push_s, mispred_s, pred_s;
  logic [BHT_IDX_W-1:0] lk_idx_s, hd_idx_s;
  logic [1:0]           upd_ctr_s, lk_ctr_s;
  logic [31:0]          rec_s;

  // Lookup, head compare and queue control decisions
  always_comb begin
    run_s     = (state_q == S_RUN);
    empty_s   = (cnt_q == '0);
    full_s    = (cnt_q == (QPTR_W+1)'(QDEPTH));
    lk_idx_s  = inst_addr_i[BHT_IDX_W+1:2];
    hd_idx_s  = qe_idx_q[rd_ptr_q];
    pop_s     = run_s & ex_resolve_i & ~empty_s;
    upd_ctr_s = sat_upd(bht_q[hd_idx_s], ex_taken_i);
`ifdef BP_BHT_BYPASS_EN
    if (pop_s && (hd_idx_s == lk_idx_s)) begin
      lk_ctr_s = upd_ctr_s;
    end else begin
      lk_ctr_s = bht_q[lk_idx_s];
    end
`else
    lk_ctr_s  = bht_q[lk_idx_s];
`endif
    pred_s    = run_s & bp_isbranch_i & inst_valid_i & lk_ctr_s[1];
    mispred_s = pop_s & ((ex_taken_i != qe_taken_q[rd_ptr_q]) |
                         (ex_taken_i & (ex_target_i != qe_target_q[rd_ptr_q])));
    // A mispredict makes the younger instruction wrong-path, so its push is dropped
    push_s    = run_s & inst_valid_i & bp_isbranch_i & ~hold_i & ~full_s & ~mispred_s;
    rec_s     = ex_taken_i ? ex_target_i : qe_fall_q[rd_ptr_q];
  end

  // Next-state for FSM, pointers, occupancy and flush
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    flush_addr_d = flush_addr_q;
    case (state_q)
      S_INIT: begin
        init_idx_d = init_idx_q + BHT_IDX_W'(1);
        if (init_idx_q == BHT_IDX_W'(BHT_N - 1)) begin
          state_d = S_RUN;
        end else begin
          state_d = S_INIT;
        end
      end
      S_RUN: begin
        if (mispred_s) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
    if (mispred_s) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      flush_addr_d = rec_s;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + QPTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + QPTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + (QPTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (QPTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      flush_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      flush_q      <= mispred_s;
      flush_addr_q <= flush_addr_d;
    end
  end

  // BHT sweep during INIT, counter training on every pop
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      bht_q[init_idx_q] <= 2'b01;
    end else if (pop_s) begin
      bht_q[hd_idx_s] <= upd_ctr_s;
    end
  end

  // Prediction queue storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      qe_taken_q[wr_ptr_q]  <= pred_s;
      qe_target_q[wr_ptr_q] <= bp_target_i;
      qe_fall_q[wr_ptr_q]   <= inst_addr_i + 32'd4;
      qe_idx_q[wr_ptr_q]    <= lk_idx_s;
    end
  end

  assign pred_taken_o = pred_s;
  assign pred_addr_o  = pred_s ? bp_target_i : 32'h0;
  assign flush_o      = flush_q;
  assign flush_addr_o = flush_addr_q;
  assign q_full_o     = (state_q == S_INIT) | full_s;

endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl: queue-based reference model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_bp_ctrl;

  logic        clk, rst;
  logic        hold_i, inst_valid_i, bp_isbranch_i, ex_resolve_i, ex_taken_i;
  logic [31:0] inst_addr_i, bp_target_i, ex_target_i;
  logic        pred_taken_o, flush_o, q_full_o;
  logic [31:0] pred_addr_o, flush_addr_o;

  int vectors = 0;
  int miscompares = 0;

  bp_ctrl dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .inst_valid_i(inst_valid_i),
    .inst_addr_i(inst_addr_i), .bp_isbranch_i(bp_isbranch_i), .bp_target_i(bp_target_i),
    .ex_resolve_i(ex_resolve_i), .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .pred_taken_o(pred_taken_o), .pred_addr_o(pred_addr_o), .flush_o(flush_o),
    .flush_addr_o(flush_addr_o), .q_full_o(q_full_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          taken;
    logic [31:0] tgt;
    logic [31:0] fall;
    int          idx;
  } ent_t;

  ent_t        mq[$];
  int          m_bht[16];
  int          m_mode;      // 0 = sweeping, 1 = running, 2 = flush cycle
  int          m_init_n;
  bit          m_flush;
  logic [31:0] m_faddr;
  ent_t        m_e;
  bit          m_p, m_pop, m_mis, m_push;

  function automatic int sat(input int c, input bit tk);
    if (tk) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit m_pred();
    int c;
    if (m_mode != 1 || !inst_valid_i || !bp_isbranch_i) return 1'b0;
    c = m_bht[idx_of(inst_addr_i)];
`ifdef BP_BHT_BYPASS_EN
    if (ex_resolve_i && mq.size() > 0 && mq[0].idx == idx_of(inst_addr_i))
      c = sat(c, ex_taken_i);
`endif
    return c >= 2;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_init_n = 0; mq.delete(); m_flush = 1'b0; m_faddr = 32'h0;
  endtask

  // Compare, then advance the model with the inputs the next posedge will sample
  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!rst) m_reset();
      m_p = m_pred();
      chk("pred_taken", {31'h0, pred_taken_o}, {31'h0, m_p});
      chk("pred_addr", pred_addr_o, m_p ? bp_target_i : 32'h0);
      chk("flush", {31'h0, flush_o}, {31'h0, m_flush});
      chk("flush_addr", flush_addr_o, m_faddr);
      chk("q_full", {31'h0, q_full_o}, {31'h0, (m_mode == 0) || (mq.size() == 4)});
      if (rst) begin
        case (m_mode)
          0: begin
            m_bht[m_init_n] = 1;
            m_init_n++;
            m_flush = 1'b0;
            if (m_init_n == 16) m_mode = 1;
          end
          1: begin
            m_pop = ex_resolve_i && mq.size() > 0;
            m_mis = 1'b0;
            if (m_pop) begin
              m_e = mq[0];
              m_mis = (ex_taken_i != m_e.taken) || (ex_taken_i && ex_target_i != m_e.tgt);
              m_bht[m_e.idx] = sat(m_bht[m_e.idx], ex_taken_i);
            end
            m_push = inst_valid_i && bp_isbranch_i && !hold_i && mq.size() < 4 && !m_mis;
            if (m_mis) begin
              mq.delete();
              m_flush = 1'b1;
              m_faddr = ex_taken_i ? ex_target_i : m_e.fall;
              m_mode  = 2;
            end else begin
              m_flush = 1'b0;
              if (m_pop) void'(mq.pop_front());
              if (m_push) mq.push_back('{m_p, bp_target_i, inst_addr_i + 32'd4, idx_of(inst_addr_i)});
            end
          end
          default: begin
            m_flush = 1'b0;
            m_mode  = 1;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [31:0] a, input bit br, input logic [31:0] t,
                     input bit h, input bit r, input bit tk, input logic [31:0] et);
    @(posedge clk);
    #1;
    inst_valid_i = v; inst_addr_i = a; bp_isbranch_i = br; bp_target_i = t;
    hold_i = h; ex_resolve_i = r; ex_taken_i = tk; ex_target_i = et;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic br(input logic [31:0] a, input logic [31:0] t);
    cyc(1'b1, a, 1'b1, t, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic res(input bit tk, input logic [31:0] et);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, tk, et);
  endtask

  initial begin
    rst = 1'b0;
    hold_i = 1'b0; inst_valid_i = 1'b0; inst_addr_i = 32'h0; bp_isbranch_i = 1'b0;
    bp_target_i = 32'h0; ex_resolve_i = 1'b0; ex_taken_i = 1'b0; ex_target_i = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_q_full", {31'h0, q_full_o}, 32'h1);
    chk("rst_flush", {31'h0, flush_o}, 32'h0);
    chk("rst_flush_addr", flush_addr_o, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // BHT sweep takes 16 cycles
    repeat (15) idle();
    chk("init_q_full", {31'h0, q_full_o}, 32'h1);
    br(32'h100, 32'h80);
    chk("run_q_full", {31'h0, q_full_o}, 32'h0);
    chk("first_pred", {31'h0, pred_taken_o}, 32'h0);

    // Train idx 0 up to strongly taken
    res(1'b1, 32'h80);
    idle();
    chk("t2_flush", {31'h0, flush_o}, 32'h1);
    chk("t2_flush_addr", flush_addr_o, 32'h80);
    br(32'h100, 32'h80);
    chk("t2_pred_weak", {31'h0, pred_taken_o}, 32'h1);
    res(1'b1, 32'h80);
    br(32'h100, 32'h80);
    chk("t2_pred", {31'h0, pred_taken_o}, 32'h1);
    chk("t2_pred_addr", pred_addr_o, 32'h80);

    // Predicted taken, resolves not-taken
    res(1'b0, 32'h0);
    idle();
    chk("t4_flush", {31'h0, flush_o}, 32'h1);
    chk("t4_flush_addr", flush_addr_o, 32'h104);
    cyc(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4_pred_ctr2", {31'h0, pred_taken_o}, 32'h1);

    // Predicted not-taken, resolves taken to 0x200
    br(32'h104, 32'h300);
    chk("t3_pred", {31'h0, pred_taken_o}, 32'h0);
    res(1'b1, 32'h200);
    idle();
    chk("t3_flush", {31'h0, flush_o}, 32'h1);
    chk("t3_flush_addr", flush_addr_o, 32'h200);
    res(1'b1, 32'h999);
    idle();
    chk("t3_empty_resolve", {31'h0, flush_o}, 32'h0);

    // Fill the queue, then exercise blocked push and push+pop
    br(32'h108, 32'h500);
    br(32'h10C, 32'h504);
    br(32'h110, 32'h508);
    br(32'h114, 32'h50C);
    br(32'h118, 32'h510);
    chk("t5_full", {31'h0, q_full_o}, 32'h1);
    cyc(1'b1, 32'h118, 1'b1, 32'h510, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_full_blocks", {31'h0, q_full_o}, 32'h1);
    cyc(1'b1, 32'h11C, 1'b1, 32'h514, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("t5_after_pop", {31'h0, q_full_o}, 32'h0);
    br(32'h120, 32'h518);
    chk("t5_pushpop", {31'h0, q_full_o}, 32'h0);
    idle();
    chk("t5_refull", {31'h0, q_full_o}, 32'h1);
    repeat (4) res(1'b0, 32'h0);
    idle();
    chk("t5_drained", {31'h0, q_full_o}, 32'h0);
    chk("t5_no_flush", {31'h0, flush_o}, 32'h0);

    // Same-index update and lookup in one cycle
    br(32'h124, 32'h400);
    cyc(1'b1, 32'h124, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 32'h400);
`ifdef BP_BHT_BYPASS_EN
    chk("t6_bypass", {31'h0, pred_taken_o}, 32'h1);
`else
    chk("t6_nobypass", {31'h0, pred_taken_o}, 32'h0);
`endif
    idle();
    chk("t6_flush_addr", flush_addr_o, 32'h400);
    res(1'b1, 32'h999);
    idle();
    chk("t6_push_dropped", {31'h0, flush_o}, 32'h0);

    // Reset while a flush is pending
    br(32'h128, 32'h600);
    res(1'b1, 32'h600);
    idle();
    chk("rr_flush_pending", {31'h0, flush_o}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rr_flush_dropped", {31'h0, flush_o}, 32'h0);
    chk("rr_q_full", {31'h0, q_full_o}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (15) idle();
    chk("rr_init_q_full", {31'h0, q_full_o}, 32'h1);
    br(32'h128, 32'h600);
    chk("rr_resweep_pred", {31'h0, pred_taken_o}, 32'h0);

    // Mixed traffic over a few indices, checked by the model only
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 3)) * 32'd4, 1'($urandom_range(0, 1)),
          32'h700 + 32'($urandom_range(0, 1)) * 32'h10, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h700 + 32'($urandom_range(0, 1)) * 32'h10);
    end
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
